// File: rtl/mac_pkg.sv
// Shared constants for the 4x4 MAC array and its feeder: element widths,
// array dimension and the feeder FSM state encoding.
package mac_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 24;
  localparam int unsigned N      = 4;
  localparam int unsigned IDX_W  = 2;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

endpackage

// File: rtl/mac_matrix_mem.sv
// 4x4 register file: one synchronous write port, synchronous clear and a
// flat read bus exposing all elements, element (r,c) at [(r*N+c)*DATA_W +: DATA_W].
module mac_matrix_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned N      = 4
) (
  input  logic                     clock,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [1:0]               wr_row,
  input  logic [1:0]               wr_col,
  input  logic [DATA_W-1:0]        wr_data,
  output logic [N*N*DATA_W-1:0]    rd_flat
);

  logic [N*N*DATA_W-1:0] mem_q;
  logic [3:0]            wr_idx;

  assign wr_idx  = {wr_row, wr_col};
  assign rd_flat = mem_q;

  always_ff @(posedge clock) begin
    if (clear) begin
      mem_q <= '0;
    end else if (wr_en) begin
      mem_q[32'(wr_idx) * DATA_W +: DATA_W] <= wr_data;
    end
  end

endmodule

// File: rtl/mac_feeder.sv
// Sequencer feeding the MAC array: holds feature and weight matrices and emits
// the skewed activation wavefront while latching weights along anti-diagonals.
module mac_feeder #(
  parameter int unsigned DATA_W = mac_pkg::DATA_W,
  parameter int unsigned ACC_W  = mac_pkg::ACC_W,
  parameter int unsigned N      = mac_pkg::N,
  parameter int unsigned DRAIN  = 3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  wr_sel,
  input  logic [1:0]            wr_row,
  input  logic [1:0]            wr_col,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic                  start,
  output logic [N*DATA_W-1:0]   a_out,
  output logic [N*N*DATA_W-1:0] w_out,
  output logic [ACC_W-1:0]      carry_in,
  output logic                  valid,
  output logic                  busy,
  output logic                  done,
  output logic                  wr_err
);

  import mac_pkg::*;

  localparam int unsigned STEP_W   = 3;
  localparam int unsigned DRAIN_W  = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;
  localparam int unsigned LAST_RUN = 2 * N - 2;

  logic [1:0]             state_q, state_d;
  logic [STEP_W-1:0]      step_q, step_d;
  logic [DRAIN_W-1:0]     drain_q, drain_d;
  logic [N*DATA_W-1:0]    a_d;
  logic [N*N*DATA_W-1:0]  w_d;
  logic                   valid_d, busy_d, done_d, wr_err_d;

  logic [N*N*DATA_W-1:0]  f_flat, w_flat, f_eff, w_eff;
  logic                   mem_wr;
  logic [3:0]             wr_idx;

  logic                   byp_vld, byp_sel;
  logic [3:0]             byp_idx;
  logic [DATA_W-1:0]      byp_data;

  // Writes land only while idle; anything else is rejected and flagged.
  assign mem_wr   = wr_en && (state_q == S_IDLE);
  assign wr_idx   = {wr_row, wr_col};
  assign carry_in = '0;

  mac_matrix_mem #(.DATA_W(DATA_W), .N(N)) u_feat_mem (
    .clock   (clock),
    .clear   (reset),
    .wr_en   (mem_wr && !wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_flat (f_flat)
  );

  mac_matrix_mem #(.DATA_W(DATA_W), .N(N)) u_wgt_mem (
    .clock   (clock),
    .clear   (reset),
    .wr_en   (mem_wr && wr_sel),
    .wr_row  (wr_row),
    .wr_col  (wr_col),
    .wr_data (wr_data),
    .rd_flat (w_flat)
  );

  // A write colliding with start commits, but the sequence must see the old
  // value: remember it and substitute it on the read side for this run.
  always_ff @(posedge clock) begin
    if (reset) begin
      byp_vld  <= 1'b0;
      byp_sel  <= 1'b0;
      byp_idx  <= '0;
      byp_data <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      byp_vld  <= wr_en;
      byp_sel  <= wr_sel;
      byp_idx  <= wr_idx;
      byp_data <= wr_sel ? w_flat[32'(wr_idx) * DATA_W +: DATA_W]
                         : f_flat[32'(wr_idx) * DATA_W +: DATA_W];
    end
  end

  always_comb begin
    f_eff = f_flat;
    w_eff = w_flat;
    if (byp_vld && !byp_sel) f_eff[32'(byp_idx) * DATA_W +: DATA_W] = byp_data;
    if (byp_vld && byp_sel)  w_eff[32'(byp_idx) * DATA_W +: DATA_W] = byp_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      step_q  <= '0;
      drain_q <= '0;
      a_out   <= '0;
      w_out   <= '0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      wr_err  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      drain_q <= drain_d;
      a_out   <= a_d;
      w_out   <= w_d;
      valid   <= valid_d;
      busy    <= busy_d;
      done    <= done_d;
      wr_err  <= wr_err_d;
    end
  end

  // Element (i,j) is on the wavefront at step i+j (0-based): activation lane i
  // takes F[i][j] and weight lane (i,j) latches W[i][j] on that step.
  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    drain_d  = drain_q;
    a_d      = a_out;
    w_d      = w_out;
    valid_d  = valid;
    busy_d   = busy;
    done_d   = 1'b0;
    wr_err_d = wr_en && (state_q != S_IDLE);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          w_d     = '0;
          step_d  = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        a_d     = '0;
        for (int unsigned i = 0; i < N; i++) begin
          for (int unsigned j = 0; j < N; j++) begin
            if (32'(step_q) == i + j) begin
              a_d[i * DATA_W +: DATA_W]       = f_eff[(i * N + j) * DATA_W +: DATA_W];
              w_d[(i * N + j) * DATA_W +: DATA_W] = w_eff[(i * N + j) * DATA_W +: DATA_W];
            end
          end
        end
        step_d = step_q + STEP_W'(1);
        if (step_q == STEP_W'(LAST_RUN)) state_d = S_FLUSH;
      end
      S_FLUSH: begin
        valid_d = 1'b1;
        busy_d  = 1'b1;
        a_d     = '0;
        drain_d = '0;
        state_d = S_DRAIN;
      end
      S_DRAIN: begin
        valid_d = 1'b0;
        busy_d  = 1'b1;
        if (drain_q == DRAIN_W'(DRAIN)) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end else begin
          drain_d = drain_q + DRAIN_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mac_feeder.sv
// Bench for mac_feeder: directed scenarios plus random traffic, every cycle
// compared against a sequence-offset reference model of the feeder.
module tb_mac_feeder;

  localparam int unsigned DW  = 8;
  localparam int unsigned AW  = 24;
  localparam int unsigned NN  = 4;
  localparam int unsigned DR  = 3;
  localparam int          SEQ_LEN = 2 * NN + 1 + DR;

  typedef logic [DW-1:0] mat_t [1:4][1:4];

  logic               clock = 1'b0;
  logic               reset, wr_en, wr_sel, start;
  logic [1:0]         wr_row, wr_col;
  logic [DW-1:0]      wr_data;
  logic [NN*DW-1:0]   a_out;
  logic [NN*NN*DW-1:0] w_out;
  logic [AW-1:0]      carry_in;
  logic               valid, busy, done, wr_err;

  mac_feeder #(.DATA_W(DW), .ACC_W(AW), .N(NN), .DRAIN(DR)) dut (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_sel   (wr_sel),
    .wr_row   (wr_row),
    .wr_col   (wr_col),
    .wr_data  (wr_data),
    .start    (start),
    .a_out    (a_out),
    .w_out    (w_out),
    .carry_in (carry_in),
    .valid    (valid),
    .busy     (busy),
    .done     (done),
    .wr_err   (wr_err)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: memories, a snapshot taken at start, and the offset d
  // (edges since the accepted start) from which every output follows.
  mat_t            fm, wm, fs, ws;
  bit              active = 1'b0;
  int              d = 0;
  logic [NN*DW-1:0]    e_a = '0;
  logic [NN*NN*DW-1:0] e_w = '0;
  logic            e_valid = 1'b0, e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic model_clear();
    for (int i = 1; i <= 4; i++)
      for (int j = 1; j <= 4; j++) begin
        fm[i][j] = '0;
        wm[i][j] = '0;
      end
  endtask

  task automatic model_edge();
    int t, c, r, k;
    e_done = 1'b0;
    e_err  = 1'b0;
    if (reset) begin
      model_clear();
      active = 1'b0;
      e_a = '0; e_w = '0; e_valid = 1'b0; e_busy = 1'b0;
      return;
    end
    e_err = wr_en && active;
    if (active) begin
      d++;
      e_valid = (d >= 1) && (d <= 2 * NN);
      e_busy  = (d >= 1) && (d < SEQ_LEN);
      e_a = '0;
      if (d >= 1 && d <= 2 * NN) begin
        t = d - 1;
        for (int i = 1; i <= 4; i++) begin
          c = t - i + 2;
          if (c >= 1 && c <= 4) e_a[(i-1)*DW +: DW] = fs[i][c];
        end
        for (int i = 1; i <= 4; i++)
          for (int j = 1; j <= 4; j++)
            if (i + j - 2 == t) e_w[((i-1)*NN + (j-1))*DW +: DW] = ws[i][j];
      end
      if (d == SEQ_LEN) begin
        e_done = 1'b1;
        active = 1'b0;
      end
    end else begin
      if (start) begin
        fs = fm; ws = wm;
        active = 1'b1;
        d = 0;
        e_w = '0;
      end
      if (wr_en) begin
        r = int'(wr_row) + 1;
        k = int'(wr_col) + 1;
        if (wr_sel) wm[r][k] = wr_data;
        else        fm[r][k] = wr_data;
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    chk("a_out",    128'(a_out),    128'(e_a));
    chk("w_out",    128'(w_out),    128'(e_w));
    chk("valid",    128'(valid),    128'(e_valid));
    chk("busy",     128'(busy),     128'(e_busy));
    chk("done",     128'(done),     128'(e_done));
    chk("wr_err",   128'(wr_err),   128'(e_err));
    chk("carry_in", 128'(carry_in), 128'(0));
  endtask

  task automatic write_elem(input bit sel, input int r, input int c, input logic [DW-1:0] v);
    wr_en = 1'b1; wr_sel = sel;
    wr_row = 2'(r - 1); wr_col = 2'(c - 1); wr_data = v;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Runs until the DUT pulses done (bounded); returns edges taken.
  task automatic run_to_done(output int m);
    m = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      m++;
      if (done) break;
    end
    chk("done_seen", 128'(done), 128'(1));
  endtask

  int m, vcnt, dcnt, done_m;
  logic [NN*DW-1:0] tmp_a;

  initial begin
    int fvals [16] = '{4,0,2,1, 4,3,2,0, 4,3,0,1, 4,3,2,1};
    model_clear();
    reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; start = 1'b0;
    wr_row = '0; wr_col = '0; wr_data = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Directed load and wavefront timing
    for (int i = 1; i <= 4; i++)
      for (int j = 1; j <= 4; j++) begin
        write_elem(1'b0, i, j, DW'(fvals[(i-1)*4 + (j-1)]));
        write_elem(1'b1, i, j, DW'(j));
      end
    pulse_start();
    vcnt = 0; done_m = 0;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (valid) vcnt++;
      if (done && done_m == 0) done_m = k;
      if (k == 4) begin
        tmp_a = {8'd4, 8'd3, 8'd2, 8'd1};
        chk("step3_a", 128'(a_out), 128'(tmp_a));
        chk("step3_w14", 128'(w_out[3*DW +: DW]),  128'(4));
        chk("step3_w23", 128'(w_out[6*DW +: DW]),  128'(3));
        chk("step3_w32", 128'(w_out[9*DW +: DW]),  128'(2));
        chk("step3_w41", 128'(w_out[12*DW +: DW]), 128'(1));
      end
      if (k == 7) begin
        tmp_a = {8'd1, 8'd0, 8'd0, 8'd0};
        chk("step6_a", 128'(a_out), 128'(tmp_a));
      end
      if (k == 8) chk("step7_a", 128'(a_out), 128'(0));
    end
    chk("valid_len", 128'(vcnt), 128'(2 * NN));
    chk("done_lat", 128'(done_m), 128'(SEQ_LEN));

    // Random contents, then back-to-back start in the done cycle
    for (int i = 1; i <= 4; i++)
      for (int j = 1; j <= 4; j++) begin
        write_elem(1'b0, i, j, DW'($urandom));
        write_elem(1'b1, i, j, DW'($urandom));
      end
    pulse_start();
    run_to_done(m);
    pulse_start();
    run_to_done(m);
    chk("replay_len", 128'(m), 128'(SEQ_LEN));
    tick();

    // Write during busy is dropped; start mid-run is ignored
    pulse_start();
    repeat (3) tick();
    wr_en = 1'b1; wr_sel = 1'($urandom); wr_row = 2'($urandom); wr_col = 2'($urandom);
    wr_data = DW'($urandom);
    tick();
    wr_en = 1'b0;
    tick();
    pulse_start();
    run_to_done(m);
    chk("len_ignored_start", 128'(m + 6), 128'(SEQ_LEN));
    pulse_start();
    run_to_done(m);

    // Reset mid-sequence cancels done and clears memories
    pulse_start();
    repeat (6) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    dcnt = 0;
    for (int k = 0; k < 15; k++) begin
      tick();
      if (done) dcnt++;
    end
    chk("no_done_after_reset", 128'(dcnt), 128'(0));
    pulse_start();
    run_to_done(m);
    chk("zero_w_after_reset", 128'(w_out), 128'(0));

    // Random traffic, including start colliding with a write
    for (int k = 0; k < 400; k++) begin
      reset   = ($urandom_range(0, 99) == 0);
      start   = ($urandom_range(0, 7) == 0);
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_sel  = 1'($urandom);
      wr_row  = 2'($urandom);
      wr_col  = 2'($urandom);
      wr_data = DW'($urandom);
      tick();
    end
    reset = 1'b0; start = 1'b0; wr_en = 1'b0;
    repeat (15) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
